// File: rtl/savestate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : savestate_sequencer
// Description : Moves a core's save-state between its 16-bit state RAM and a
//               64-bit word-oriented save-state controller.
//               Save : for every word w, read 4 halfwords (4*w..4*w+3) from
//                      the state RAM, pack them little-endian into ss_din and
//                      hand the word over with a one-cycle ss_req.
//               Load : for every word w, request it with a one-cycle ss_req,
//                      capture ss_dout on ss_ack and write its 4 halfwords
//                      back to the state RAM.
//               Optional build macro SS_HEADER_EN: a header word
//               {16'h5353, 16'h0001, 16'h0000, WORDS[15:0]} is written as
//               controller word 0 on save and verified on load (mismatch
//               sets ss_err and aborts without touching the RAM).
//
// Parameters  : WORDS   64-bit state words per operation (1..65535)
//               MEM_AW  state-RAM halfword address width (2^MEM_AW >= 4*WORDS)
//
// Ports       : clk_sys    in   system clock (only clock of this block)
//               reset_n    in   asynchronous active-low reset
//               ss_save    in   start-save pulse (accepted in IDLE only)
//               ss_load    in   start-load pulse (accepted in IDLE only)
//               ss_din     out  64-bit save word to controller
//               ss_dout    in   64-bit load word from controller
//               ss_addr    out  controller word index
//               ss_rnw     out  direction, 1 = load
//               ss_req     out  one-cycle word request
//               ss_be      out  byte enables
//               ss_ack     in   controller word acknowledge
//               ss_busy    out  operation in progress
//               mem_addr   out  state-RAM halfword address
//               mem_rd     out  state-RAM read strobe (read data 1 cycle later)
//               mem_wr     out  state-RAM write strobe
//               mem_wdata  out  state-RAM write data
//               mem_rdata  in   state-RAM read data
//               ss_err     out  sticky error, cleared when next op starts
//
// Revision    : 1.0 - initial release
// ============================================================================
module savestate_sequencer #(
    parameter int WORDS  = 512,
    parameter int MEM_AW = 11
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ss_save,
    input  logic              ss_load,
    output logic [63:0]       ss_din,
    input  logic [63:0]       ss_dout,
    output logic [25:0]       ss_addr,
    output logic              ss_rnw,
    output logic              ss_req,
    output logic [7:0]        ss_be,
    input  logic              ss_ack,
    output logic              ss_busy,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              ss_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_FETCH = 3'd1,
        S_REQ   = 3'd2,
        S_ACK   = 3'd3,
        L_REQ   = 3'd4,
        L_ACK   = 3'd5,
        L_STORE = 3'd6,
        DONE    = 3'd7
    } state_t;

`ifdef SS_HEADER_EN
    // Word 0 on the controller side is the header; data words sit one up.
    localparam logic [63:0] c_HEADER  = {16'h5353, 16'h0001, 16'h0000, 16'(WORDS)};
    localparam logic [15:0] c_LAST    = 16'(WORDS);
    localparam logic [15:0] c_DATA_OFS = 16'd1;
`else
    localparam logic [15:0] c_LAST    = 16'(WORDS - 1);
    localparam logic [15:0] c_DATA_OFS = 16'd0;
`endif

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [15:0]         r_w;
    logic [2:0]          r_cnt;
    logic                r_req;
    logic                r_rnw;
    logic                r_busy;
    logic                r_rd;
    logic                r_wr;
    logic                r_err;
    logic [63:0]         r_din;
    logic [25:0]         r_addr;
    logic [7:0]          r_be;
    logic [MEM_AW-1:0]   r_maddr;
    logic [15:0]         r_wdata;
    logic [63:0]         r_ld;
    // Read-return pipeline: a read issued in cycle t returns in t+1.
    logic                r_cap_valid;
    logic [1:0]          r_cap_lane;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t              w_state_nx;
    logic [15:0]         w_w_nx;
    logic [2:0]          w_cnt_nx;
    logic                w_req_nx;
    logic                w_rnw_nx;
    logic                w_busy_nx;
    logic                w_rd_nx;
    logic                w_wr_nx;
    logic                w_err_nx;
    logic [63:0]         w_din_nx;
    logic [25:0]         w_addr_nx;
    logic [7:0]          w_be_nx;
    logic [MEM_AW-1:0]   w_maddr_nx;
    logic [15:0]         w_wdata_nx;
    logic [63:0]         w_ld_nx;

    // Index of the data word in the state RAM (header, if any, has none).
    logic [15:0]         w_dw;
    assign w_dw = r_w - c_DATA_OFS;

    always_comb begin
        w_state_nx = r_state;
        w_w_nx     = r_w;
        w_cnt_nx   = r_cnt;
        w_req_nx   = 1'b0;
        w_rnw_nx   = r_rnw;
        w_busy_nx  = r_busy;
        w_rd_nx    = 1'b0;
        w_wr_nx    = 1'b0;
        w_err_nx   = r_err;
        w_din_nx   = r_din;
        w_addr_nx  = r_addr;
        w_be_nx    = r_be;
        w_maddr_nx = r_maddr;
        w_wdata_nx = r_wdata;
        w_ld_nx    = r_ld;

        // Drop each returning halfword into its lane of the save word.
        if (r_cap_valid) begin
            w_din_nx[{r_cap_lane, 4'b0000} +: 16] = mem_rdata;
        end

        case (r_state)
            IDLE: begin
                w_w_nx    = 16'd0;
                w_cnt_nx  = 3'd0;
                w_busy_nx = 1'b0;
                if (ss_save) begin
                    w_state_nx = S_FETCH;
                    w_busy_nx  = 1'b1;
                    w_err_nx   = 1'b0;
                end else if (ss_load) begin
                    w_state_nx = L_REQ;
                    w_busy_nx  = 1'b1;
                    w_err_nx   = 1'b0;
                    w_req_nx   = 1'b1;
                    w_rnw_nx   = 1'b1;
                    w_addr_nx  = 26'd0;
                    w_be_nx    = 8'hFF;
                end
            end

            S_FETCH: begin
`ifdef SS_HEADER_EN
                if (r_w == 16'd0) begin
                    w_din_nx   = c_HEADER;
                    w_state_nx = S_REQ;
                    w_req_nx   = 1'b1;
                    w_rnw_nx   = 1'b0;
                    w_addr_nx  = 26'd0;
                    w_be_nx    = 8'hFF;
                end else
`endif
                begin
                    // cnt 0..3 issue reads; cnt 5 is the cycle the last
                    // halfword is captured, so the word is complete in S_REQ.
                    if (r_cnt < 3'd4) begin
                        w_rd_nx    = 1'b1;
                        w_maddr_nx = MEM_AW'({w_dw, r_cnt[1:0]});
                    end
                    if (r_cnt == 3'd5) begin
                        w_cnt_nx   = 3'd0;
                        w_state_nx = S_REQ;
                        w_req_nx   = 1'b1;
                        w_rnw_nx   = 1'b0;
                        w_addr_nx  = 26'(r_w);
                        w_be_nx    = 8'hFF;
                    end else begin
                        w_cnt_nx = r_cnt + 3'd1;
                    end
                end
            end

            S_REQ: begin
                w_state_nx = S_ACK;
            end

            S_ACK: begin
                if (ss_ack) begin
                    if (r_w == c_LAST) begin
                        w_state_nx = DONE;
                    end else begin
                        w_w_nx     = r_w + 16'd1;
                        w_state_nx = S_FETCH;
                    end
                end
            end

            L_REQ: begin
                w_state_nx = L_ACK;
            end

            L_ACK: begin
                if (ss_ack) begin
                    w_ld_nx = ss_dout;
`ifdef SS_HEADER_EN
                    if (r_w == 16'd0) begin
                        if (ss_dout != c_HEADER) begin
                            w_err_nx   = 1'b1;
                            w_state_nx = DONE;
                        end else begin
                            w_w_nx     = 16'd1;
                            w_state_nx = L_REQ;
                            w_req_nx   = 1'b1;
                            w_rnw_nx   = 1'b1;
                            w_addr_nx  = 26'd1;
                        end
                    end else
`endif
                    begin
                        w_cnt_nx   = 3'd0;
                        w_state_nx = L_STORE;
                    end
                end
            end

            L_STORE: begin
                w_wr_nx    = 1'b1;
                w_maddr_nx = MEM_AW'({w_dw, r_cnt[1:0]});
                w_wdata_nx = r_ld[{r_cnt[1:0], 4'b0000} +: 16];
                if (r_cnt == 3'd3) begin
                    w_cnt_nx = 3'd0;
                    if (r_w == c_LAST) begin
                        w_state_nx = DONE;
                    end else begin
                        w_w_nx     = r_w + 16'd1;
                        w_state_nx = L_REQ;
                        w_req_nx   = 1'b1;
                        w_rnw_nx   = 1'b1;
                        w_addr_nx  = 26'(r_w + 16'd1);
                    end
                end else begin
                    w_cnt_nx = r_cnt + 3'd1;
                end
            end

            DONE: begin
                w_busy_nx  = 1'b0;
                w_state_nx = IDLE;
            end

            default: begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_w         <= 16'd0;
            r_cnt       <= 3'd0;
            r_req       <= 1'b0;
            r_rnw       <= 1'b0;
            r_busy      <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_err       <= 1'b0;
            r_din       <= 64'd0;
            r_addr      <= 26'd0;
            r_be        <= 8'd0;
            r_maddr     <= '0;
            r_wdata     <= 16'd0;
            r_ld        <= 64'd0;
            r_cap_valid <= 1'b0;
            r_cap_lane  <= 2'd0;
        end else begin
            r_state     <= w_state_nx;
            r_w         <= w_w_nx;
            r_cnt       <= w_cnt_nx;
            r_req       <= w_req_nx;
            r_rnw       <= w_rnw_nx;
            r_busy      <= w_busy_nx;
            r_rd        <= w_rd_nx;
            r_wr        <= w_wr_nx;
            r_err       <= w_err_nx;
            r_din       <= w_din_nx;
            r_addr      <= w_addr_nx;
            r_be        <= w_be_nx;
            r_maddr     <= w_maddr_nx;
            r_wdata     <= w_wdata_nx;
            r_ld        <= w_ld_nx;
            r_cap_valid <= r_rd;
            r_cap_lane  <= r_maddr[1:0];
        end
    end

    assign ss_din    = r_din;
    assign ss_addr   = r_addr;
    assign ss_rnw    = r_rnw;
    assign ss_req    = r_req;
    assign ss_be     = r_be;
    assign ss_busy   = r_busy;
    assign mem_addr  = r_maddr;
    assign mem_rd    = r_rd;
    assign mem_wr    = r_wr;
    assign mem_wdata = r_wdata;
    assign ss_err    = r_err;

endmodule
`default_nettype wire
